mips_mc_ctrl: RTL and testbench

Multi-cycle successor to the single-cycle MIPS controller: a Moore/Mealy FSM that sequences one instruction over several cycles through a shared ALU and one unified memory port. It sits beside the multi-cycle datapath inside the `mips` top. It takes opcode, funct and ALU zero from the datapath, and drives all datapath enables and muxes. Memory access uses a ready handshake with parametrised wait tolerance and timeout.

---
 rtl/mips_mc_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/write-back over a shared ALU and one memory port.
// Optional build macro MC_CTRL_PERF_EN adds perf_cycles/perf_instr counters.
module mips_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Option,
  input  logic [5:0] Function,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] Regdst,
  output logic [1:0] MemtoReg,
  output logic       Regwrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] Sign,
  output logic       illegal,
  output logic       halted,
  output logic [3:0] state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instr
`endif
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd15
  } st_e;

  st_e             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            timeout;
  logic            is_rtype, is_alu_r, is_subu, is_jr, is_jal, is_j;
  logic            is_beq, is_ori, is_lui, is_lw, is_sw;

  // Instruction classification from the IR fields
  assign is_rtype = (Option == OP_RTYPE);
  assign is_alu_r = is_rtype && ((Function == FN_ADDU) || (Function == FN_SUBU) || (Function == FN_SLL));
  assign is_subu  = is_rtype && (Function == FN_SUBU);
  assign is_jr    = is_rtype && (Function == FN_JR);
  assign is_j     = (Option == OP_J);
  assign is_jal   = (Option == OP_JAL);
  assign is_beq   = (Option == OP_BEQ);
  assign is_ori   = (Option == OP_ORI);
  assign is_lui   = (Option == OP_LUI);
  assign is_lw    = (Option == OP_LW);
  assign is_sw    = (Option == OP_SW);

  // A ready arriving at the limit wins, so timeout requires mem_ready low
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LIMIT) && !mem_ready;
  assign state   = 4'(state_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Wait counter restarts on every state change, counts stalled memory cycles
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)) && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    Regdst   = 2'b00;
    MemtoReg = 2'b00;
    Regwrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = ALU_ADD;
    Sign     = 2'b00;
    illegal  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        // Gated by reset so the reset-held outputs stay quiet
        if (mem_ready && reset) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b01;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Sign    = 2'b01;
        if (is_lw || is_sw) begin
          state_d = S_MEMADR;
        end else if (is_alu_r || is_ori || is_lui) begin
          state_d = S_EXEC;
        end else if (is_beq) begin
          state_d = S_BRANCH;
        end else if (is_j || is_jal || is_jr) begin
          state_d = S_JUMP;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Sign    = 2'b01;
        state_d = is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_MEMWB: begin
        Regwrite = 1'b1;
        MemtoReg = 2'b01;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (is_ori || is_lui) begin
          ALUSrcB = 2'b10;
          ALUOp   = is_lui ? ALU_LUI : ALU_OR;
        end else begin
          ALUOp = is_subu ? ALU_SUB : ALU_ADD;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        Regwrite = 1'b1;
        Regdst   = is_rtype ? 2'b01 : 2'b00;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SUB;
        PCSrc   = 2'b01;
        PCWrite = Zero;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          Regwrite = 1'b1;
          Regdst   = 2'b10;
          MemtoReg = 2'b10;
        end
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  logic instr_done;

  // An instruction retires when a completing state hands back to FETCH
  always_comb begin
    instr_done = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_DECODE, S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP: instr_done = 1'b1;
        default: instr_done = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cycles <= '0;
      perf_instr  <= '0;
    end else begin
      if (state_q != S_HALT) perf_cycles <= perf_cycles + 32'd1;
      if (instr_done)        perf_instr  <= perf_instr + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: stimulus queues hand-computed per-cycle outputs, a negedge monitor compares.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] sgn;
    logic       ill;
    logic       hlt;
  } exp_t;

  localparam exp_t E_FW      = '{st:4'd0, mrd:1'b1, default:'0};
  localparam exp_t E_FG      = '{st:4'd0, mrd:1'b1, irw:1'b1, pcw:1'b1, asb:2'b01, default:'0};
  localparam exp_t E_DEC     = '{st:4'd1, asb:2'b11, sgn:2'b01, default:'0};
  localparam exp_t E_DEC_ILL = '{st:4'd1, asb:2'b11, sgn:2'b01, ill:1'b1, default:'0};
  localparam exp_t E_MADR    = '{st:4'd2, asa:1'b1, asb:2'b10, sgn:2'b01, default:'0};
  localparam exp_t E_MRD     = '{st:4'd3, mrd:1'b1, iord:1'b1, default:'0};
  localparam exp_t E_MWB     = '{st:4'd4, rw:1'b1, m2r:2'b01, default:'0};
  localparam exp_t E_MWR     = '{st:4'd5, mwr:1'b1, iord:1'b1, default:'0};
  localparam exp_t E_EX_ADD  = '{st:4'd6, asa:1'b1, default:'0};
  localparam exp_t E_EX_SUB  = '{st:4'd6, asa:1'b1, aop:3'b001, default:'0};
  localparam exp_t E_EX_ORI  = '{st:4'd6, asa:1'b1, asb:2'b10, aop:3'b010, default:'0};
  localparam exp_t E_EX_LUI  = '{st:4'd6, asa:1'b1, asb:2'b10, aop:3'b011, default:'0};
  localparam exp_t E_AWB_R   = '{st:4'd7, rw:1'b1, rdst:2'b01, default:'0};
  localparam exp_t E_AWB_I   = '{st:4'd7, rw:1'b1, default:'0};
  localparam exp_t E_BR1     = '{st:4'd8, asa:1'b1, aop:3'b001, pcsrc:2'b01, pcw:1'b1, default:'0};
  localparam exp_t E_BR0     = '{st:4'd8, asa:1'b1, aop:3'b001, pcsrc:2'b01, default:'0};
  localparam exp_t E_J       = '{st:4'd9, pcw:1'b1, pcsrc:2'b10, default:'0};
  localparam exp_t E_JAL     = '{st:4'd9, pcw:1'b1, pcsrc:2'b10, rw:1'b1, rdst:2'b10, m2r:2'b10, default:'0};
  localparam exp_t E_JR      = '{st:4'd9, pcw:1'b1, pcsrc:2'b11, default:'0};
  localparam exp_t E_HALT    = '{st:4'd15, hlt:1'b1, default:'0};

  logic       clk = 1'b0;
  logic       reset, zero, rdy;
  logic [5:0] opt, fn;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, Regwrite, ALUSrcA, illegal, halted;
  logic [1:0] PCSrc, Regdst, MemtoReg, ALUSrcB, Sign;
  logic [2:0] ALUOp;
  logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_instr;
`endif
  exp_t got;

  exp_t  q_exp[$];
  string q_nm[$];
  int    q_pc[$];
  int    q_pi[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .Option(opt), .Function(fn), .Zero(zero), .mem_ready(rdy),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .Regdst(Regdst), .MemtoReg(MemtoReg), .Regwrite(Regwrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Sign(Sign), .illegal(illegal),
    .halted(halted), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_instr(perf_instr)
`endif
  );

  assign got = {state, PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, Regdst, MemtoReg,
                Regwrite, ALUSrcA, ALUSrcB, ALUOp, Sign, illegal, halted};

  // Monitor: one expected entry per cycle, compared mid-cycle
  exp_t  m_e;
  string m_nm;
  int    m_pc, m_pi;
  always @(negedge clk) begin
    if (q_exp.size() != 0) begin
      m_e  = q_exp.pop_front();
      m_nm = q_nm.pop_front();
      m_pc = q_pc.pop_front();
      m_pi = q_pi.pop_front();
      n_checks++;
      if (got === m_e) n_pass++;
      else $display("FAIL %s: got state=%0d outs=%h, required state=%0d outs=%h",
                    m_nm, got.st, got, m_e.st, m_e);
`ifdef MC_CTRL_PERF_EN
      if (m_pc >= 0) begin
        n_checks++;
        if (perf_cycles === 32'(m_pc) && perf_instr === 32'(m_pi)) n_pass++;
        else $display("FAIL %s_perf: got cycles=%0d instr=%0d, required cycles=%0d instr=%0d",
                      m_nm, perf_cycles, perf_instr, m_pc, m_pi);
      end
`endif
    end
  end

  task automatic cyc(input logic r, input logic m, input exp_t e, input string nm,
                     input int pc = -1, input int pi = -1);
    reset = r;
    rdy   = m;
    q_exp.push_back(e);
    q_nm.push_back(nm);
    q_pc.push_back(pc);
    q_pi.push_back(pi);
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [5:0] o, input logic [5:0] f);
    opt = o;
    fn  = f;
  endtask

  task automatic alu_instr(input logic [5:0] o, input logic [5:0] f, input exp_t ex,
                           input exp_t wb, input string nm);
    ins(o, f);
    cyc(1'b1, 1'b1, E_FG,  {nm, "_fetch"});
    cyc(1'b1, 1'b1, E_DEC, {nm, "_decode"});
    cyc(1'b1, 1'b1, ex,    {nm, "_exec"});
    cyc(1'b1, 1'b1, wb,    {nm, "_wb"});
  endtask

  task automatic short_instr(input logic [5:0] o, input logic [5:0] f, input exp_t last,
                             input string nm);
    ins(o, f);
    cyc(1'b1, 1'b1, E_FG,  {nm, "_fetch"});
    cyc(1'b1, 1'b1, E_DEC, {nm, "_decode"});
    cyc(1'b1, 1'b1, last,  {nm, "_exec"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rdy = 1'b1; zero = 1'b0; opt = '0; fn = '0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, E_FW, "reset_hold");

    alu_instr(6'h00, 6'h21, E_EX_ADD, E_AWB_R, "addu");
    // One FETCH stall ahead of subu
    cyc(1'b1, 1'b0, E_FW, "subu_fetch_wait");
    alu_instr(6'h00, 6'h23, E_EX_SUB, E_AWB_R, "subu");
    alu_instr(6'h00, 6'h00, E_EX_ADD, E_AWB_R, "nop");
    alu_instr(6'h0d, 6'h00, E_EX_ORI, E_AWB_I, "ori");
    alu_instr(6'h0f, 6'h00, E_EX_LUI, E_AWB_I, "lui");

    // lw with three MEMRD wait cycles: 8 cycles total
    ins(6'h23, 6'h00);
    cyc(1'b1, 1'b1, E_FG,   "lw_fetch");
    cyc(1'b1, 1'b1, E_DEC,  "lw_decode");
    cyc(1'b1, 1'b1, E_MADR, "lw_memadr");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, E_MRD, "lw_memrd_wait");
    cyc(1'b1, 1'b1, E_MRD,  "lw_memrd_done");
    cyc(1'b1, 1'b1, E_MWB,  "lw_memwb");

    ins(6'h2b, 6'h00);
    cyc(1'b1, 1'b1, E_FG,   "sw_fetch");
    cyc(1'b1, 1'b1, E_DEC,  "sw_decode");
    cyc(1'b1, 1'b1, E_MADR, "sw_memadr");
    cyc(1'b1, 1'b1, E_MWR,  "sw_memwr");

    zero = 1'b1;
    short_instr(6'h04, 6'h00, E_BR1, "beq_taken");
    zero = 1'b0;
    short_instr(6'h04, 6'h00, E_BR0, "beq_not_taken");
    short_instr(6'h02, 6'h00, E_J,   "j");
    short_instr(6'h03, 6'h00, E_JAL, "jal");
    short_instr(6'h00, 6'h08, E_JR,  "jr");

    ins(6'h3f, 6'h00);
    cyc(1'b1, 1'b1, E_FG,      "ill_op_fetch");
    cyc(1'b1, 1'b1, E_DEC_ILL, "ill_op_decode");
    cyc(1'b1, 1'b0, E_FW,      "ill_op_refetch");
    cyc(1'b1, 1'b0, E_FW,      "ill_op_refetch2");
    ins(6'h00, 6'h2a);
    cyc(1'b1, 1'b1, E_FG,      "ill_fn_fetch");
    cyc(1'b1, 1'b1, E_DEC_ILL, "ill_fn_decode");

    // Ready arriving exactly at the wait limit completes the fetch
    ins(6'h02, 6'h00);
    cyc(1'b1, 1'b0, E_FW, "limit_wait_first");
    for (int i = 1; i < 15; i++) cyc(1'b1, 1'b0, E_FW, "limit_wait");
    cyc(1'b1, 1'b1, E_FG,  "limit_ready_wins");
    cyc(1'b1, 1'b1, E_DEC, "limit_decode");
    cyc(1'b1, 1'b1, E_J,   "limit_jump");

    // Timeout: 16 stalled FETCH cycles, then HALT until reset
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, E_FW, "timeout_wait");
    cyc(1'b1, 1'b0, E_HALT, "halt_entered");
    cyc(1'b1, 1'b1, E_HALT, "halt_holds_ready");
    cyc(1'b1, 1'b1, E_HALT, "halt_holds_ready2");
    cyc(1'b0, 1'b1, E_HALT, "halt_reset_edge");
    cyc(1'b1, 1'b0, E_FW,   "halt_after_reset");

    // Reset in the middle of a MEMWR wait
    ins(6'h2b, 6'h00);
    cyc(1'b1, 1'b1, E_FG,   "swr_fetch");
    cyc(1'b1, 1'b1, E_DEC,  "swr_decode");
    cyc(1'b1, 1'b1, E_MADR, "swr_memadr");
    cyc(1'b1, 1'b0, E_MWR,  "swr_wait");
    cyc(1'b1, 1'b0, E_MWR,  "swr_wait2");
    cyc(1'b0, 1'b0, E_MWR,  "swr_reset_edge");
    cyc(1'b1, 1'b0, E_FW,   "swr_after_reset", 0, 0);

    alu_instr(6'h00, 6'h21, E_EX_ADD, E_AWB_R, "addu2");
    cyc(1'b1, 1'b0, E_FW, "addu2_next_fetch", 5, 1);

    @(posedge clk);
    for (int i = 0; i < 10 && q_exp.size() != 0; i++) @(posedge clk);
    if (q_exp.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries, required 0", q_exp.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
